banco_registros: RTL

Parametrised multi-entry register bank; the next-generation successor of the single 32-bit register used in the image-filter datapath. It provides NUM_REGS words of DATA_W bits, two prioritised write ports (C = core, V = video/filter side) and two independent registered read ports (A, B). Read ports drive plain muxed outputs with a valid strobe; there are no tri-state buses. It sits between the processor datapath and the filter pipeline as shared scratch/coefficient storage.

---
 rtl/banco_registros_pkg.sv | 51 +++++
 rtl/banco_registros_wr_arb.sv | 87 ++++++++
 rtl/banco_registros.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/banco_registros_pkg.sv
// -----------------------------------------------------------------------------
// banco_registros_pkg
// Shared definitions for the banco_registros register bank and for other
// dual-writer blocks in the filter design:
//   - default word width and entry count
//   - collision counter width and saturation value
//   - write-port priority encoding (core port C wins over video port V)
// -----------------------------------------------------------------------------
package banco_registros_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;

    localparam int                    COLL_CNT_W   = 8;
    localparam logic [COLL_CNT_W-1:0] COLL_CNT_MAX = 8'd255;

    // Which write port owns a target when both may request it
    typedef enum logic [1:0] {
        WR_SEL_NONE = 2'b00,
        WR_SEL_C    = 2'b01,
        WR_SEL_V    = 2'b10
    } wr_sel_e;

    // Fixed priority: the core port always beats the video port
    function automatic wr_sel_e wr_prio(input logic req_c, input logic req_v);
        wr_sel_e sel;
        if (req_c) begin
            sel = WR_SEL_C;
        end else if (req_v) begin
            sel = WR_SEL_V;
        end else begin
            sel = WR_SEL_NONE;
        end
        return sel;
    endfunction

    // Saturating increment for the collision counter
    function automatic logic [COLL_CNT_W-1:0] coll_cnt_next(
        input logic [COLL_CNT_W-1:0] cnt,
        input logic                  inc
    );
        logic [COLL_CNT_W-1:0] nxt;
        if (inc && (cnt != COLL_CNT_MAX)) begin
            nxt = cnt + 8'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/banco_registros_wr_arb.sv
// -----------------------------------------------------------------------------
// banco_wr_arb
// Write arbiter for banco_registros. Turns the two write requests (C and V)
// into per-entry write enables and per-entry write data, and flags a
// collision when both ports write the same in-range address in one cycle.
//
// Ports:
//   cs_c, we_c, addr_c, din_c : core write port (higher priority)
//   cs_v, we_v, addr_v, din_v : video write port
//   wr_en     [NUM_REGS]      : entry i is written this cycle
//   wr_data   [NUM_REGS]      : data for entry i (valid when wr_en[i])
//   collision                 : C and V hit the same in-range address
// Purely combinational; the caller registers whatever it needs.
// -----------------------------------------------------------------------------
module banco_wr_arb
    import banco_registros_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_R0  = 0
) (
    input  logic                               cs_c,
    input  logic                               we_c,
    input  logic [ADDR_W-1:0]                  addr_c,
    input  logic [DATA_W-1:0]                  din_c,
    input  logic                               cs_v,
    input  logic                               we_v,
    input  logic [ADDR_W-1:0]                  addr_v,
    input  logic [DATA_W-1:0]                  din_v,
    output logic [NUM_REGS-1:0]                wr_en,
    output logic [NUM_REGS-1:0][DATA_W-1:0]    wr_data,
    output logic                               collision
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic                req_c_s;
    logic                req_v_s;
    logic                in_rng_c_s;
    logic                in_rng_v_s;
    logic [NUM_REGS-1:0] hit_c_s;
    logic [NUM_REGS-1:0] hit_v_s;

    // Request qualification and collision detection (entry 0 still counts)
    always_comb begin
        req_c_s    = cs_c & we_c;
        req_v_s    = cs_v & we_v;
        in_rng_c_s = ({1'b0, addr_c} < NUM_REGS_L);
        in_rng_v_s = ({1'b0, addr_v} < NUM_REGS_L);
        collision  = req_c_s & req_v_s & in_rng_c_s & in_rng_v_s &
                     (addr_c == addr_v);
    end

    // Per-entry decode; out-of-range addresses match no entry and are dropped
    always_comb begin
        wr_en   = {NUM_REGS{1'b0}};
        wr_data = {(NUM_REGS * DATA_W){1'b0}};
        hit_c_s = {NUM_REGS{1'b0}};
        hit_v_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            hit_c_s[i] = req_c_s && (addr_c == ADDR_W'(i));
            hit_v_s[i] = req_v_s && (addr_v == ADDR_W'(i));
            case (wr_prio(hit_c_s[i], hit_v_s[i]))
                WR_SEL_C: begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = din_c;
                end
                WR_SEL_V: begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = din_v;
                end
                default: begin
                    wr_en[i]   = 1'b0;
                    wr_data[i] = {DATA_W{1'b0}};
                end
            endcase
            // Hard-wired zero entry never accepts data
            if ((ZERO_R0 != 0) && (i == 0)) begin
                wr_en[i] = 1'b0;
            end else begin
                wr_en[i] = wr_en[i];
            end
        end
    end

endmodule

// File: rtl/banco_registros.sv
// -----------------------------------------------------------------------------
// banco_registros
// NUM_REGS x DATA_W register bank with two prioritised write ports (C over V)
// and two independent registered read ports (A, B).
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   CSa, ADDRa -> DoA, VALIDa   : read port A (1-cycle latency, DoA holds
//                                 when CSa is low)
//   CSb, ADDRb -> DoB, VALIDb   : read port B
//   CSc, WEc, ADDRc, DinC       : core write port (wins on same address)
//   CSv, WEv, ADDRv, DinV       : video write port
//   COLLISION                   : registered pulse, C and V hit same entry
//   COLL_CNT                    : saturating collision count since reset
//
// Build option: define WRITE_BYPASS_EN to let a read see the data being
// written to the same entry in the same cycle. Without it the read returns
// the pre-write contents.
// -----------------------------------------------------------------------------
module banco_registros
    import banco_registros_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_R0  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CSa,
    input  logic [ADDR_W-1:0]     ADDRa,
    output logic [DATA_W-1:0]     DoA,
    output logic                  VALIDa,
    input  logic                  CSb,
    input  logic [ADDR_W-1:0]     ADDRb,
    output logic [DATA_W-1:0]     DoB,
    output logic                  VALIDb,
    input  logic                  CSc,
    input  logic                  WEc,
    input  logic [ADDR_W-1:0]     ADDRc,
    input  logic [DATA_W-1:0]     DinC,
    input  logic                  CSv,
    input  logic                  WEv,
    input  logic [ADDR_W-1:0]     ADDRv,
    input  logic [DATA_W-1:0]     DinV,
    output logic                  COLLISION,
    output logic [COLL_CNT_W-1:0] COLL_CNT
);

    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]             regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]           wr_en_s;
    logic [NUM_REGS-1:0][DATA_W-1:0] wr_data_s;
    logic                          coll_s;

    logic [1:0][ADDR_W-1:0]        rd_addr_s;
    logic [1:0][DATA_W-1:0]        rd_word_s;

    logic [DATA_W-1:0]             do_a_r;
    logic [DATA_W-1:0]             do_b_r;
    logic                          valid_a_r;
    logic                          valid_b_r;
    logic                          coll_r;
    logic [COLL_CNT_W-1:0]         coll_cnt_r;

    banco_wr_arb #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_R0  (ZERO_R0)
    ) u_wr_arb (
        .cs_c      (CSc),
        .we_c      (WEc),
        .addr_c    (ADDRc),
        .din_c     (DinC),
        .cs_v      (CSv),
        .we_v      (WEv),
        .addr_v    (ADDRv),
        .din_v     (DinV),
        .wr_en     (wr_en_s),
        .wr_data   (wr_data_s),
        .collision (coll_s)
    );

    // Storage: cleared on reset, otherwise each entry loads when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s[i]) begin
                    regs_r[i] <= wr_data_s[i];
                end
            end
        end
    end

    // Gather both read addresses so the mux logic is written once
    always_comb begin
        rd_addr_s    = {(2 * ADDR_W){1'b0}};
        rd_addr_s[0] = ADDRa;
        rd_addr_s[1] = ADDRb;
    end

    // Read mux: out-of-range and the hard-wired zero entry return 0
    always_comb begin
        rd_word_s = {(2 * DATA_W){1'b0}};
        for (int p = 0; p < 2; p++) begin
            if ({1'b0, rd_addr_s[p]} < NUM_REGS_L) begin
                if ((ZERO_R0 != 0) && (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
                    rd_word_s[p] = {DATA_W{1'b0}};
`ifdef WRITE_BYPASS_EN
                end else if (wr_en_s[rd_addr_s[p]]) begin
                    // Arbiter already resolved C-over-V for this entry
                    rd_word_s[p] = wr_data_s[rd_addr_s[p]];
`endif
                end else begin
                    rd_word_s[p] = regs_r[rd_addr_s[p]];
                end
            end else begin
                rd_word_s[p] = {DATA_W{1'b0}};
            end
        end
    end

    // Read-port output registers: data holds while the port is idle
    always_ff @(posedge clk) begin
        if (rst) begin
            do_a_r    <= {DATA_W{1'b0}};
            do_b_r    <= {DATA_W{1'b0}};
            valid_a_r <= 1'b0;
            valid_b_r <= 1'b0;
        end else begin
            valid_a_r <= CSa;
            valid_b_r <= CSb;
            if (CSa) begin
                do_a_r <= rd_word_s[0];
            end
            if (CSb) begin
                do_b_r <= rd_word_s[1];
            end
        end
    end

    // Collision pulse and saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_r     <= 1'b0;
            coll_cnt_r <= {COLL_CNT_W{1'b0}};
        end else begin
            coll_r     <= coll_s;
            coll_cnt_r <= coll_cnt_next(coll_cnt_r, coll_s);
        end
    end

    assign DoA       = do_a_r;
    assign DoB       = do_b_r;
    assign VALIDa    = valid_a_r;
    assign VALIDb    = valid_b_r;
    assign COLLISION = coll_r;
    assign COLL_CNT  = coll_cnt_r;

endmodule
